uart_rx_parity_chk: RTL and testbench

Serial, frame-aware parity checker for the UART receiver, and the successor to the single-shot combinational parity compare. It accumulates parity bit by bit as the Rx FSM samples data bits, then checks the sampled parity bit against the expected value. It supports a parametrised data width and four parity modes, detects short frames, and keeps a saturating parity-error counter. It sits between the Rx sampling FSM and the status/register block.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_sat_counter.sv | 25 ++
 rtl/uart_rx_parity_chk.sv | 113 +++++++++++
 tb/tb_uart_rx_parity_chk.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART Rx definitions: parity-mode codes, checker states, expected-parity helper.
// Pure declarations; no latency or flow control of its own.
package uart_rx_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_PAR  = 2'b10
    } state_t;

    function automatic logic expected_parity(input logic [1:0] mode, input logic acc);
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter; clear beats a same-cycle increment.
// Updates one clk after i_inc/i_clr; never stalls.
module uart_sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_parity_chk.sv
// Frame-aware UART Rx parity checker with short-frame detect and saturating error count.
// par_done 1 clk after the final strobe; strobes are never back-pressured.
module uart_rx_parity_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_par_chk_en,
    input  logic [1:0]           i_par_type,
    input  logic                 i_frame_start,
    input  logic                 i_bit_valid,
    input  logic                 i_bit_in,
    input  logic                 i_par_valid,
    input  logic                 i_parity_bit,
    input  logic                 i_clr_err_cnt,
    output logic                 o_busy,
    output logic                 o_par_done,
    output logic                 o_parity_error,
    output logic                 o_len_error,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t           r_state;
    logic             r_en;
    logic [1:0]       r_type;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_par_done;
    logic             r_parity_error;
    logic             r_len_error;
    logic             w_err_inc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_en           <= 1'b0;
            r_type         <= PAR_EVEN;
            r_acc          <= 1'b0;
            r_cnt          <= '0;
            r_par_done     <= 1'b0;
            r_parity_error <= 1'b0;
            r_len_error    <= 1'b0;
        end else begin
            r_par_done <= 1'b0;
            // A new start bit wins over any strobe sampled in the same cycle.
            if (i_frame_start) begin
                r_en           <= i_par_chk_en;
                r_type         <= i_par_type;
                r_acc          <= 1'b0;
                r_cnt          <= '0;
                r_parity_error <= 1'b0;
                r_len_error    <= 1'b0;
                r_state        <= ST_DATA;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_DATA: begin
                        if (i_par_valid) begin
                            r_len_error    <= 1'b1;
                            r_parity_error <= 1'b0;
                            r_par_done     <= 1'b1;
                            r_state        <= ST_IDLE;
                        end else if (i_bit_valid) begin
                            r_acc <= r_acc ^ i_bit_in;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == LAST_BIT) begin
                                if (r_en) begin
                                    r_state <= ST_PAR;
                                end else begin
                                    r_par_done <= 1'b1;
                                    r_state    <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_PAR: begin
                        if (i_par_valid) begin
                            r_parity_error <= (i_parity_bit != expected_parity(r_type, r_acc));
                            r_par_done     <= 1'b1;
                            r_state        <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Count from the registered result so a clear in the par_done cycle wins.
    assign w_err_inc = r_par_done & r_parity_error;

    uart_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_err_inc),
        .i_clr   (i_clr_err_cnt),
        .o_count (o_err_count)
    );

    assign o_busy         = (r_state != ST_IDLE);
    assign o_par_done     = r_par_done;
    assign o_parity_error = r_parity_error;
    assign o_len_error    = r_len_error;

endmodule

// File: tb/tb_uart_rx_parity_chk.sv
// Bench for uart_rx_parity_chk: directed scenarios plus randomized frames vs a parity model.
module tb_uart_rx_parity_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       par_chk_en = 1'b0;
    logic [1:0] par_type = 2'b00;
    logic       frame_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       par_valid = 1'b0;
    logic       parity_bit = 1'b0;
    logic       clr_err_cnt = 1'b0;

    logic       busy, par_done, parity_error, len_error;
    logic [7:0] err_count;
    logic       busy2, par_done2, parity_error2, len_error2;
    logic [1:0] err_count2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    uart_rx_parity_chk #(.DATA_WIDTH(8), .ERR_CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_par_chk_en(par_chk_en), .i_par_type(par_type),
        .i_frame_start(frame_start), .i_bit_valid(bit_valid), .i_bit_in(bit_in),
        .i_par_valid(par_valid), .i_parity_bit(parity_bit), .i_clr_err_cnt(clr_err_cnt),
        .o_busy(busy), .o_par_done(par_done), .o_parity_error(parity_error),
        .o_len_error(len_error), .o_err_count(err_count)
    );

    uart_rx_parity_chk #(.DATA_WIDTH(8), .ERR_CNT_W(2)) u_dut_w2 (
        .i_clk(clk), .i_rst(rst), .i_par_chk_en(par_chk_en), .i_par_type(par_type),
        .i_frame_start(frame_start), .i_bit_valid(bit_valid), .i_bit_in(bit_in),
        .i_par_valid(par_valid), .i_parity_bit(parity_bit), .i_clr_err_cnt(clr_err_cnt),
        .o_busy(busy2), .o_par_done(par_done2), .o_parity_error(parity_error2),
        .o_len_error(len_error2), .o_err_count(err_count2)
    );

    // Reference: parity of the data bits computed by counting ones.
    function automatic logic ref_parity(input logic [8:0] d, input int n, input logic [1:0] mode);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        case (mode)
            2'b00:   return ((ones % 2) == 1);
            2'b01:   return ((ones % 2) == 0);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic note_error();
        exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
        exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic en, input logic [1:0] mode);
        par_chk_en = en; par_type = mode; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1; bit_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [8:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic send_par(input logic p);
        par_valid = 1'b1; parity_bit = p;
        tick();
        par_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        exp_cnt8 = 0; exp_cnt2 = 0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (par_done !== 1'b0) begin n_fail++; $display("FAIL reset_par_done: got %b want 0", par_done); end
        n_tests++; if (parity_error !== 1'b0 || len_error !== 1'b0) begin n_fail++; $display("FAIL reset_errors: got %b%b want 00", parity_error, len_error); end
        n_tests++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d/%0d want 0/0", err_count, err_count2); end
    endtask

    task automatic test_even_parity();
        start_frame(1'b1, 2'b00);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL even_busy_start: got %b want 1", busy); end
        send_bits(9'h0A5, 8);
        n_tests++; if (busy !== 1'b1 || par_done !== 1'b0) begin n_fail++; $display("FAIL even_pre_par: busy/done got %b%b want 10", busy, par_done); end
        send_par(1'b0);
        n_tests++; if (par_done !== 1'b1) begin n_fail++; $display("FAIL even_latency: par_done got %b want 1", par_done); end
        n_tests++; if (parity_error !== 1'b0 || len_error !== 1'b0) begin n_fail++; $display("FAIL even_errors: got %b%b want 00", parity_error, len_error); end
        tick();
        n_tests++; if (par_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL even_after: done/busy got %b%b want 00", par_done, busy); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL even_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_modes();
        start_frame(1'b1, 2'b01);
        send_bits(9'h0A5, 8);
        send_par(1'b0);
        n_tests++; if (parity_error !== 1'b1 || par_done !== 1'b1) begin n_fail++; $display("FAIL odd_error: pe/done got %b%b want 11", parity_error, par_done); end
        note_error(); tick();
        n_tests++; if (err_count !== 8'(exp_cnt8)) begin n_fail++; $display("FAIL odd_err_count: got %0d want %0d", err_count, exp_cnt8); end
        start_frame(1'b1, 2'b10);
        send_bits(9'h000, 8);
        send_par(1'b0);
        n_tests++; if (parity_error !== 1'b1) begin n_fail++; $display("FAIL mark_error: got %b want 1", parity_error); end
        note_error(); tick();
        n_tests++; if (err_count !== 8'(exp_cnt8) || err_count2 !== 2'(exp_cnt2)) begin n_fail++; $display("FAIL mark_err_count: got %0d/%0d want %0d/%0d", err_count, err_count2, exp_cnt8, exp_cnt2); end
        start_frame(1'b1, 2'b11);
        send_bits(9'($urandom_range(0, 255)), 8);
        send_par(1'b0);
        n_tests++; if (parity_error !== 1'b0 || par_done !== 1'b1) begin n_fail++; $display("FAIL space_ok: pe/done got %b%b want 01", parity_error, par_done); end
        tick();
        n_tests++; if (err_count !== 8'(exp_cnt8)) begin n_fail++; $display("FAIL space_err_count: got %0d want %0d", err_count, exp_cnt8); end
    endtask

    task automatic test_disabled();
        start_frame(1'b0, 2'b01);
        send_bits(9'h0FF, 7);
        n_tests++; if (par_done !== 1'b0) begin n_fail++; $display("FAIL dis_early_done: got %b want 0", par_done); end
        send_bit(1'b1);
        n_tests++; if (par_done !== 1'b1 || parity_error !== 1'b0 || len_error !== 1'b0) begin n_fail++; $display("FAIL dis_done: done/pe/le got %b%b%b want 100", par_done, parity_error, len_error); end
        tick();
        n_tests++; if (busy !== 1'b0 || par_done !== 1'b0) begin n_fail++; $display("FAIL dis_idle: busy/done got %b%b want 00", busy, par_done); end
        send_par(1'b1);
        n_tests++; if (par_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dis_stray_par: done/busy got %b%b want 00", par_done, busy); end
        tick();
        n_tests++; if (err_count !== 8'(exp_cnt8)) begin n_fail++; $display("FAIL dis_err_count: got %0d want %0d", err_count, exp_cnt8); end
    endtask

    task automatic test_short_frame();
        logic [8:0] d;
        logic       p;
        start_frame(1'b1, 2'b00);
        send_bits(9'h015, 5);
        send_par(1'b1);
        n_tests++; if (par_done !== 1'b1 || len_error !== 1'b1 || parity_error !== 1'b0) begin n_fail++; $display("FAIL short_len: done/le/pe got %b%b%b want 110", par_done, len_error, parity_error); end
        tick(); tick();
        n_tests++; if (len_error !== 1'b1 || err_count !== 8'(exp_cnt8)) begin n_fail++; $display("FAIL short_hold: le/cnt got %b/%0d want 1/%0d", len_error, err_count, exp_cnt8); end
        start_frame(1'b1, 2'b01);
        n_tests++; if (len_error !== 1'b0 || parity_error !== 1'b0) begin n_fail++; $display("FAIL restart_clear: le/pe got %b%b want 00", len_error, parity_error); end
        send_bits(9'h007, 3);
        start_frame(1'b1, 2'b00);
        n_tests++; if (par_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_no_done: done/busy got %b%b want 01", par_done, busy); end
        d = 9'($urandom_range(0, 255));
        p = ref_parity(d, 8, 2'b00);
        send_bits(d, 8);
        send_par(p);
        n_tests++; if (par_done !== 1'b1 || parity_error !== 1'b0 || len_error !== 1'b0) begin n_fail++; $display("FAIL after_abort: done/pe/le got %b%b%b want 100", par_done, parity_error, len_error); end
        tick();
    endtask

    task automatic test_saturation();
        clr_err_cnt = 1'b1; tick(); clr_err_cnt = 1'b0;
        exp_cnt8 = 0; exp_cnt2 = 0;
        n_tests++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin n_fail++; $display("FAIL sat_clear: got %0d/%0d want 0/0", err_count, err_count2); end
        for (int k = 1; k <= 5; k++) begin
            start_frame(1'b1, 2'b10);
            send_bits(9'($urandom_range(0, 255)), 8);
            send_par(1'b0);
            note_error(); tick();
            n_tests++; if (err_count2 !== 2'(exp_cnt2) || err_count !== 8'(exp_cnt8)) begin n_fail++; $display("FAIL sat_step%0d: got %0d/%0d want %0d/%0d", k, err_count2, err_count, exp_cnt2, exp_cnt8); end
        end
        start_frame(1'b1, 2'b10);
        send_bits(9'h000, 8);
        send_par(1'b0);
        n_tests++; if (parity_error !== 1'b1 || par_done !== 1'b1) begin n_fail++; $display("FAIL sat_sixth: pe/done got %b%b want 11", parity_error, par_done); end
        clr_err_cnt = 1'b1; tick(); clr_err_cnt = 1'b0;
        exp_cnt8 = 0; exp_cnt2 = 0;
        n_tests++; if (err_count2 !== 2'd0 || err_count !== 8'd0) begin n_fail++; $display("FAIL clr_priority: got %0d/%0d want 0/0", err_count2, err_count); end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] d;
        start_frame(1'b1, 2'b01);
        send_bits(9'h0A5, 8);
        send_par(1'b0);
        note_error(); tick();
        start_frame(1'b1, 2'b00);
        send_bits(9'h0FF, 8);
        n_tests++; if (busy !== 1'b1 || err_count === 8'd0) begin n_fail++; $display("FAIL rst_pre: busy/cnt got %b/%0d want 1/nonzero", busy, err_count); end
        rst = 1'b1; tick(); rst = 1'b0;
        exp_cnt8 = 0; exp_cnt2 = 0;
        n_tests++; if (busy !== 1'b0 || par_done !== 1'b0 || parity_error !== 1'b0 || len_error !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid: busy/done/pe/le/cnt got %b%b%b%b/%0d want 0000/0", busy, par_done, parity_error, len_error, err_count); end
        send_par(1'b1);
        n_tests++; if (par_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_stray_par: done/busy got %b%b want 00", par_done, busy); end
        // Bit 7 cleared so a wrongly counted extra '1' flips the parity.
        d = 9'($urandom_range(0, 127));
        par_chk_en = 1'b1; par_type = 2'b00; frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        send_bits(d, 7);
        n_tests++; if (busy !== 1'b1 || par_done !== 1'b0) begin n_fail++; $display("FAIL fs_bit_7: busy/done got %b%b want 10", busy, par_done); end
        send_bit(d[7]);
        send_par(ref_parity(d, 8, 2'b00));
        n_tests++; if (par_done !== 1'b1 || parity_error !== 1'b0 || len_error !== 1'b0) begin n_fail++; $display("FAIL fs_bit_ignored: done/pe/le got %b%b%b want 100", par_done, parity_error, len_error); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] d;
        logic [1:0] mode;
        logic       en, p, exp_pe, exp_le;
        int         n;
        for (int f = 0; f < 40; f++) begin
            en   = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
            d    = 9'($urandom_range(0, 255));
            n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8;
            p    = 1'($urandom_range(0, 1));
            start_frame(en, mode);
            send_bits(d, n);
            exp_le = (n < 8);
            exp_pe = en && !exp_le && (p != ref_parity(d, 8, mode));
            if (en || exp_le) send_par(p);
            n_tests++; if (par_done !== 1'b1 || parity_error !== exp_pe || len_error !== exp_le) begin n_fail++; $display("FAIL rand%0d: done/pe/le got %b%b%b want 1%b%b (en=%b mode=%0d n=%0d d=%h p=%b)", f, par_done, parity_error, len_error, exp_pe, exp_le, en, mode, n, d, p); end
            if (exp_pe) note_error();
            tick();
            n_tests++; if (err_count !== 8'(exp_cnt8) || err_count2 !== 2'(exp_cnt2)) begin n_fail++; $display("FAIL rand%0d_cnt: got %0d/%0d want %0d/%0d", f, err_count, err_count2, exp_cnt8, exp_cnt2); end
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_modes();
        test_disabled();
        test_short_frame();
        test_saturation();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
